// File: rtl/bus_mem.sv
// Word-addressed 16-bit memory slave with programmable wait states.
// A request is latched in IDLE, optionally waits, then completes with a one-cycle registered ack.
module bus_mem #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [15:0]           bus_wrdata,
  output logic [15:0]           bus_rddata,
  input  logic                  bus_cyc,
  input  logic                  bus_write,
  output logic                  bus_ack,
  output logic [1:0]            dbg_state
);

  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          WAIT_L  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [15:0]             rddata_q, rddata_d;
  logic                    ack_q, ack_d;

  logic [ADDR_WIDTH-1:0]   xfer_addr;
  logic                    xfer_write;
  logic [15:0]             xfer_wdata;
  logic                    in_range;
  logic                    mem_we;

  logic [15:0] mem [DEPTH] = '{default: 16'h0000};

  always_comb begin
    // In IDLE the live bus is used so a zero-wait request completes on its own latch edge.
    xfer_addr  = (state_q == IDLE) ? bus_addr   : addr_q;
    xfer_write = (state_q == IDLE) ? bus_write  : write_q;
    xfer_wdata = (state_q == IDLE) ? bus_wrdata : wdata_q;
    in_range   = ({1'b0, xfer_addr} < DEPTH_L);

    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (bus_cyc) begin
          addr_d  = bus_addr;
          write_d = bus_write;
          wdata_d = bus_wrdata;
          cnt_d   = WAIT_L;
          state_d = (WAIT_L == 4'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!bus_cyc) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ack_d    = (state_d == ACK);
    mem_we   = ack_d && xfer_write && in_range;
    rddata_d = rddata_q;
    if (ack_d && !xfer_write) begin
      rddata_d = in_range ? mem[xfer_addr[IDX_W-1:0]] : 16'hDEAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= 16'h0000;
      ack_q    <= 1'b0;
      rddata_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rddata_q <= rddata_d;
    end
  end

  // Memory has no reset; a reset edge only blocks the write it would otherwise commit.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[xfer_addr[IDX_W-1:0]] <= xfer_wdata;
    end
  end

  assign bus_ack    = ack_q;
  assign bus_rddata = rddata_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/bus_mem.md
BUS_MEM -- requirements
Module: bus_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14: word-address width of the bus.
REQ-002 SHALL have parameter DEPTH, default 4096: number of 16-bit words implemented, with 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter WAIT_STATES, default 1: extra cycles inserted before ack, range 0..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port bus_addr, input, ADDR_WIDTH bits: word address from the master.
REQ-007 SHALL have port bus_wrdata, input, 16 bits: write data.
REQ-008 SHALL have port bus_rddata, output, 16 bits: read data, registered.
REQ-009 SHALL have port bus_cyc, input, 1 bit: master request active.
REQ-010 SHALL have port bus_write, input, 1 bit: 1 = write, 0 = read; meaningful only while bus_cyc=1.
REQ-011 SHALL have port bus_ack, output, 1 bit: one-cycle transfer-complete strobe, registered.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-013 In IDLE, bus_cyc=1 at a clock edge SHALL latch bus_addr, bus_write and bus_wrdata, and load the wait counter with WAIT_STATES.
REQ-014 After that latch, the FSM SHALL enter ACK if WAIT_STATES=0, else WAIT.
REQ-015 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL enter ACK on the edge where the counter equals 1.
REQ-016 bus_ack SHALL be 1 exactly while in ACK, so it is high for one cycle, 1+WAIT_STATES cycles after the request edge.
REQ-017 ACK SHALL always go to IDLE, so a back-to-back request is accepted no earlier than the cycle after ack; the minimum period is WAIT_STATES+2 cycles.
REQ-018 A bus_cyc=1 seen in ACK SHALL NOT start a transaction; the master must still present bus_cyc=1 in IDLE.
REQ-019 A read SHALL drive bus_rddata = mem[latched addr] during the ack cycle, and bus_rddata SHALL hold that value until the next ack.
REQ-020 A write SHALL update mem[latched addr] with the latched data on the edge entering ACK; bus_rddata SHALL be unchanged by the write.
REQ-021 An address >= DEPTH SHALL still be acked: a read returns 16'hDEAD and a write is discarded.
REQ-022 Abort: bus_cyc=0 in WAIT SHALL return the FSM to IDLE on the next edge with no ack and no memory write.
REQ-023 Bus input changes after the latch edge SHALL NOT affect the transaction in progress.
REQ-024 Memory SHALL initialise to all zeros at time zero.

Reset
REQ-025 While rst=1 at an edge, the FSM SHALL go to IDLE, bus_ack SHALL be 0, bus_rddata SHALL be 16'h0000, and the wait counter SHALL be 0.
REQ-026 Reset during WAIT or ACK SHALL cancel the transaction: no ack is issued and no write occurs if reset precedes the ACK-entry edge.
REQ-027 Reset SHALL NOT clear memory contents.
REQ-028 A request held with bus_cyc=1 across the deassertion of reset SHALL be accepted on the first edge with rst=0.

Verification
REQ-029 Write/read, WAIT_STATES=1: write addr 0x0010 data 0xBEEF, then read 0x0010 -> each ack exactly 2 cycles after the request edge; read returns 0xBEEF.
REQ-030 WAIT_STATES=0: read 0x0000 after reset -> ack 1 cycle after request, rddata 0x0000; bus_cyc held high -> next ack 2 cycles later.
REQ-031 Out of range, DEPTH=4096: write 0x1234 to addr 0x1000, then read 0x1000 -> both acked, read 0xDEAD; read 0x0FFF is unaffected.
REQ-032 Abort, WAIT_STATES=3: write addr 5 data 0x1111, drop bus_cyc after 1 cycle -> no ack; a later read of addr 5 returns 0x0000.
REQ-033 Reset mid-WAIT, WAIT_STATES=3: assert rst 1 cycle after a write request -> no ack, no write; memory contents written before reset read back intact.
REQ-034 Input stability: change bus_addr and bus_wrdata during WAIT -> the write lands at the originally latched address with the originally latched data.
